// File: rtl/hex_entry_pkg.sv
// hex_entry_pkg: shared types, key indices and edit helpers for the
// hex_entry pushbutton value-entry block.
package hex_entry_pkg;

    // Debounce FSM states, one instance per key.
    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    // Bit positions of the key functions within KEY.
    localparam int KEY_INC    = 0;
    localparam int KEY_DEC    = 1;
    localparam int KEY_SEL    = 2;
    localparam int KEY_COMMIT = 3;

    localparam int NIBBLES = 4;
    localparam int DIGIT_W = 2;
    localparam int VALUE_W = 4 * NIBBLES;

    // Nibble-local edit: only the selected digit moves, wrapping modulo 16.
    // INC and DEC together cancel.
    function automatic logic [VALUE_W-1:0] nibble_edit(
        input logic [VALUE_W-1:0] v,
        input logic [DIGIT_W-1:0] d,
        input logic               up,
        input logic               down
    );
        logic [VALUE_W-1:0] result;
        logic [3:0]         nib;
        result = v;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (d == DIGIT_W'(i)) begin
                nib = v[4*i +: 4];
                if (up && !down) begin
                    nib = nib + 4'd1;
                end else if (down && !up) begin
                    nib = nib - 4'd1;
                end
                result[4*i +: 4] = nib;
            end
        end
        return result;
    endfunction

    // Carrying edit: the selected digit's weight is added to or subtracted
    // from the whole value, so carries and borrows ripple upward.
    function automatic logic [VALUE_W-1:0] carry_edit(
        input logic [VALUE_W-1:0] v,
        input logic [DIGIT_W-1:0] d,
        input logic               up,
        input logic               down
    );
        logic [VALUE_W-1:0] step;
        logic [VALUE_W-1:0] result;
        step   = VALUE_W'(1) << {d, 2'b00};
        result = v;
        if (up && !down) begin
            result = v + step;
        end else if (down && !up) begin
            result = v - step;
        end
        return result;
    endfunction

endpackage

// File: rtl/hex_entry_key_debounce.sv
// key_debounce: two-flop synchronizer plus debounce FSM for one active-low
// pushbutton. Emits a single-cycle press pulse once the key has been seen
// low for DEBOUNCE_CYCLES consecutive samples after leaving RELEASED;
// release is debounced the same way but produces no pulse.
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic key,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    deb_state_t       state;

    // Bring the asynchronous key into the clock domain; reset reads as released.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Debounce FSM: the entry transition into a wait state is not itself
    // counted; DEBOUNCE_CYCLES further stable samples complete the change.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state <= RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                RELEASED: begin
                    cnt <= '0;
                    if (!sync2) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    cnt <= '0;
                    if (sync2) begin
                        state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync2) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hex_entry.sv
// hex_entry: four-key hex value entry. Debounced INC/DEC/SEL/COMMIT events
// edit a 16-bit value one nibble at a time and commit it to DATA with a
// one-cycle VALID strobe.
// Build option: define HEX_ENTRY_CARRY_EN to make INC/DEC carry and borrow
// across nibbles; otherwise each nibble wraps on its own.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLK,
    input  logic        CLR_N,
    input  logic [3:0]  KEY,
    output logic [15:0] VALUE,
    output logic [1:0]  DIGIT,
    output logic [15:0] DATA,
    output logic        VALID
);

    logic [3:0]  events;
    logic [15:0] next_value;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLK  (CLK),
            .CLR_N(CLR_N),
            .key  (KEY[k]),
            .press(events[k])
        );
    end

    // Edited value for this cycle's events, always using the current DIGIT.
    always_comb begin
        next_value = VALUE;
`ifdef HEX_ENTRY_CARRY_EN
        next_value = carry_edit(VALUE, DIGIT, events[KEY_INC], events[KEY_DEC]);
`else
        next_value = nibble_edit(VALUE, DIGIT, events[KEY_INC], events[KEY_DEC]);
`endif
    end

    // Apply events: DATA captures the pre-edit VALUE, so a commit alongside
    // an edit records the old value while the edit still takes effect.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            VALUE <= '0;
            DIGIT <= '0;
            DATA  <= '0;
            VALID <= 1'b0;
        end else begin
            VALUE <= next_value;
            DIGIT <= DIGIT + {1'b0, events[KEY_SEL]};
            if (events[KEY_COMMIT]) begin
                DATA <= VALUE;
            end
            VALID <= events[KEY_COMMIT];
        end
    end

endmodule

// File: tb/tb_hex_entry.sv
// tb_hex_entry: directed and randomized checks of hex_entry with
// DEBOUNCE_CYCLES=4 against a press-level behavioural model.
module tb_hex_entry;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        CLR_N;
    logic [3:0]  KEY;
    logic [15:0] VALUE;
    logic [1:0]  DIGIT;
    logic [15:0] DATA;
    logic        VALID;

    int checks = 0;
    int failures = 0;
    int valid_seen = 0;

    // Model state: what the outputs should read once all events have landed.
    int m_value;
    int m_data;
    int m_digit;

    always #5 clk = ~clk;

    hex_entry #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLK  (clk),
        .CLR_N(CLR_N),
        .KEY  (KEY),
        .VALUE(VALUE),
        .DIGIT(DIGIT),
        .DATA (DATA),
        .VALID(VALID)
    );

    // Count every cycle in which VALID is high.
    always @(negedge clk) begin
        if (VALID === 1'b1) valid_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Result of one INC/DEC pair applied at digit d.
    function automatic int model_edit(input int v, input int d, input int inc, input int dec);
        int delta;
        int nib;
        delta = inc - dec;
`ifdef HEX_ENTRY_CARRY_EN
        return (v + delta * (1 << (4 * d))) & 32'hFFFF;
`else
        nib = (v >> (4 * d)) & 15;
        nib = (nib + delta + 16) % 16;
        return (v & ~(15 << (4 * d)) & 32'hFFFF) | (nib << (4 * d));
`endif
    endfunction

    task automatic apply_model(input logic [3:0] mask);
        int old_value;
        old_value = m_value;
        if (mask[3]) m_data = old_value;
        m_value = model_edit(old_value, m_digit, int'(mask[0]), int'(mask[1]));
        m_digit = (m_digit + int'(mask[2])) % 4;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_value"}, 32'(VALUE), 32'(m_value));
        check({tag, "_digit"}, 32'(DIGIT), 32'(m_digit));
        check({tag, "_data"},  32'(DATA),  32'(m_data));
    endtask

    task automatic do_reset();
        KEY   = 4'hF;
        CLR_N = 1'b0;
        step(3);
        CLR_N = 1'b1;
        m_value = 0;
        m_data  = 0;
        m_digit = 0;
    endtask

    // Clean press of all keys in mask at once, held for hold cycles,
    // then released for gap cycles.
    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        int v0;
        int exp_data_new;
        v0 = valid_seen;
        exp_data_new = mask[3] ? m_value : m_data;
        KEY = ~mask;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (VALID === 1'b1) check("data_at_valid", 32'(DATA), 32'(exp_data_new));
        end
        KEY = 4'hF;
        step(gap);
        apply_model(mask);
        check_outputs("press");
        check("valid_pulses", 32'(valid_seen - v0), mask[3] ? 32'd1 : 32'd0);
    endtask

    // Low pulse shorter than the debounce window: must be ignored.
    task automatic glitch(input logic [3:0] mask, input int len);
        int v0;
        v0 = valid_seen;
        KEY = ~mask;
        step(len);
        KEY = 4'hF;
        step(5);
        check_outputs("glitch");
        check("glitch_valid", 32'(valid_seen - v0), 32'd0);
    endtask

    initial begin
        int v0;
        logic [3:0] mask;

        // Reset state.
        KEY   = 4'hF;
        CLR_N = 1'b0;
        step(3);
        check("rst_value", 32'(VALUE), 32'h0);
        check("rst_data",  32'(DATA),  32'h0);
        check("rst_digit", 32'(DIGIT), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        CLR_N = 1'b1;
        m_value = 0;
        m_data  = 0;
        m_digit = 0;
        step(2);

        // Bounce rejection, then a clean hold: the first sampling edge is
        // cycle 0, so VALUE changes on the edge DC+3 cycles later.
        v0 = valid_seen;
        for (int i = 0; i < 5; i++) begin
            KEY[0] = 1'b0;
            step(2);
            KEY[0] = 1'b1;
            step(2);
        end
        check("bounce_none", 32'(VALUE), 32'h0);
        KEY[0] = 1'b0;
        step(DC + 3);
        check("bounce_early", 32'(VALUE), 32'h0);
        step(1);
        check("bounce_inc", 32'(VALUE), 32'h1);
        step(1);
        KEY = 4'hF;
        step(10);
        apply_model(4'b0001);
        check_outputs("bounce_after");
        check("bounce_valid", 32'(valid_seen - v0), 32'd0);

        // Edit and commit.
        do_reset();
        press(4'b0100, 10, 10);
        press(4'b0100, 10, 10);
        for (int i = 0; i < 3; i++) press(4'b0001, 10, 10);
        press(4'b1000, 10, 10);
        check("edit_digit", 32'(DIGIT), 32'd2);
        check("edit_value", 32'(VALUE), 32'h0300);
        check("edit_data",  32'(DATA),  32'h0300);

        // Wrap and carry on INC.
        do_reset();
        for (int i = 0; i < 15; i++) press(4'b0001, 9, 9);
        check("wrap_pre", 32'(VALUE), 32'h000F);
        press(4'b0001, 9, 9);
`ifdef HEX_ENTRY_CARRY_EN
        check("wrap_inc", 32'(VALUE), 32'h0010);
`else
        check("wrap_inc", 32'(VALUE), 32'h0000);
`endif

        // Wrap and borrow on DEC.
        do_reset();
        press(4'b0010, 9, 9);
`ifdef HEX_ENTRY_CARRY_EN
        check("wrap_dec", 32'(VALUE), 32'hFFFF);
`else
        check("wrap_dec", 32'(VALUE), 32'h000F);
`endif

        // Simultaneous events.
        do_reset();
        for (int i = 0; i < 5; i++) press(4'b0001, 9, 9);
        press(4'b0011, 9, 9);
        check("sim_incdec", 32'(VALUE), 32'h0005);
        press(4'b1001, 9, 9);
        check("sim_commit_data",  32'(DATA),  32'h0005);
        check("sim_commit_value", 32'(VALUE), 32'h0006);
        press(4'b1111, 9, 9);
        check("sim_all_value", 32'(VALUE), 32'h0006);
        check("sim_all_data",  32'(DATA),  32'h0006);
        check("sim_all_digit", 32'(DIGIT), 32'd1);

        // Reset during PRESS_WAIT with the key held through release of reset.
        do_reset();
        KEY = 4'b1110;
        step(5);
        CLR_N = 1'b0;
        step(2);
        CLR_N = 1'b1;
        v0 = valid_seen;
        step(6);
        check("rst_mid_none", 32'(VALUE), 32'h0);
        step(4);
        check("rst_mid_inc", 32'(VALUE), 32'h1);
        KEY = 4'hF;
        step(10);
        check("rst_mid_once", 32'(VALUE), 32'h1);
        check("rst_mid_valid", 32'(valid_seen - v0), 32'd0);
        m_value = 1;
        m_data  = 0;
        m_digit = 0;

        // Randomized clean presses and sub-window glitches.
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) begin
                glitch(mask, int'($urandom_range(1, DC - 1)));
            end else begin
                press(mask, int'($urandom_range(8, 12)), int'($urandom_range(8, 12)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
